two_of_five_scan_display: RTL and testbench

Multiplexed multi-digit driver for 2-out-of-5 coded decimal values. It latches DIGITS coded digits on a load strobe and decodes each to active-low seven-segment patterns. The digits are time-multiplexed onto one shared segment bus with active-low digit enables and anti-ghosting blanking. It is the sequential successor to the single-digit combinational decoder and sits between the counter/arithmetic datapath and the board display.

---
 rtl/two_of_five_scan_display_if.sv | 23 ++
 rtl/two_of_five_scan_display.sv | 123 ++++++++++++
 tb/tb_two_of_five_scan_display.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/two_of_five_scan_display_if.sv
// Load/segment bus between the datapath (master) and the multiplexed
// 2-of-5 display driver (slave).
interface two_of_five_scan_display_if #(
    parameter int DIGITS = 4
);
    logic                  load_i;
    logic [5*DIGITS-1:0]   code_i;
    logic [DIGITS-1:0]     valid_i;
    logic                  err_clr_i;
    logic [6:0]            seg_o;
    logic [DIGITS-1:0]     an_o;
    logic                  err_o;

    modport master (
        output load_i, code_i, valid_i, err_clr_i,
        input  seg_o, an_o, err_o
    );

    modport slave (
        input  load_i, code_i, valid_i, err_clr_i,
        output seg_o, an_o, err_o
    );
endinterface

// File: rtl/two_of_five_scan_display.sv
// Latches DIGITS 2-of-5 coded digits and time-multiplexes them onto an
// active-low seven-segment bus with per-slot blanking and a sticky error flag.
module two_of_five_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    two_of_five_scan_display_if.slave    bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [5*DIGITS-1:0]   code_q, code_d;
    logic [DIGITS-1:0]     valid_q, valid_d;
    logic                  err_q, err_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic [4:0]            cur_code;
    logic                  cur_valid;
    logic                  load_bad;

    function automatic logic two_hot(input logic [4:0] c);
        int n;
        n = 0;
        for (int b = 0; b < 5; b++) n += int'(c[b]);
        return n == 2;
    endfunction

    // All ten two-hot codes are legal digits, so the default arm is exactly
    // the invalid-code dash.
    function automatic logic [6:0] decode(input logic [4:0] c);
        case (c)
            5'b00110: return 7'b0000001;
            5'b10001: return 7'b1001111;
            5'b01001: return 7'b0010010;
            5'b11000: return 7'b0000110;
            5'b00101: return 7'b1001100;
            5'b10100: return 7'b0100100;
            5'b01100: return 7'b0100000;
            5'b00011: return 7'b0001111;
            5'b10010: return 7'b0000000;
            5'b01010: return 7'b0000100;
            default:  return 7'b1111110;
        endcase
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would infer a latch.
        cur_code  = '0;
        cur_valid = 1'b0;
        load_bad  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_code  = code_q[5*i +: 5];
                cur_valid = valid_q[i];
            end
            if (bus.valid_i[i] && !two_hot(bus.code_i[5*i +: 5])) load_bad = 1'b1;
        end
    end

    always_comb begin
        pcnt_d  = pcnt_q + PW'(1);
        idx_d   = idx_q;
        code_d  = code_q;
        valid_d = valid_q;
        err_d   = err_q;
        seg_d   = 7'h7F;
        an_d    = '1;

        if (pcnt_q == PW'(SCAN_DIV - 1)) begin
            pcnt_d = '0;
            idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end

        if (bus.load_i) begin
            code_d  = bus.code_i;
            valid_d = bus.valid_i;
        end

        // Set after clear so a same-cycle collision leaves the flag set.
        if (bus.err_clr_i) err_d = 1'b0;
        if (bus.load_i && load_bad) err_d = 1'b1;

        if (pcnt_q >= PW'(BLANK)) begin
            for (int i = 0; i < DIGITS; i++) an_d[i] = (idx_q != IW'(i));
            seg_d = cur_valid ? decode(cur_code) : 7'h7F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q  <= '0;
            idx_q   <= '0;
            // NOTE: the digit store is cleared as well, so nothing stale can
            // be shown once scanning restarts after reset.
            code_q  <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
            seg_q   <= 7'h7F;
            an_q    <= '1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.seg_o = seg_q;
    assign bus.an_o  = an_q;
    assign bus.err_o = err_q;
endmodule

// File: tb/tb_two_of_five_scan_display.sv
// Scoreboarded bench: a time-based reference model queues the expected outputs
// for each edge and a negedge monitor compares them with the DUT.
module tb_two_of_five_scan_display;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    typedef struct {
        logic [6:0]        seg;
        logic [DIGITS-1:0] an;
        logic              err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    two_of_five_scan_display_if #(.DIGITS(DIGITS)) bus ();

    two_of_five_scan_display #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [4:0] codes [10] = '{5'b00110, 5'b10001, 5'b01001, 5'b11000, 5'b00101,
                               5'b10100, 5'b01100, 5'b00011, 5'b10010, 5'b01010};
    string lit [10] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG",
                        "ACDFG", "ACDEFG", "ABC", "ABCDEFG", "ABCDFG"};

    exp_t       exp_q [$];
    logic [4:0] m_code  [DIGITS];
    logic       m_valid [DIGITS];
    logic       m_err;
    int         m_t;
    bit         m_started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [4:0] c, input logic v);
        logic [6:0] p;
        if (!v) return 7'h7F;
        for (int d = 0; d < 10; d++) begin
            if (c == codes[d]) begin
                p = '1;
                for (int i = 0; i < lit[d].len(); i++)
                    p[6 - (int'(lit[d][i]) - 65)] = 1'b0;
                return p;
            end
        end
        return 7'b1111110;
    endfunction

    // Reference model: position in the scan follows from cycles since reset.
    initial begin
        exp_t e;
        int   pos, slot;
        bit   bad;
        forever begin
            @(posedge clk);
            if (rst) begin
                e.seg = 7'h7F; e.an = '1; e.err = 1'b0;
                exp_q.push_back(e);
                m_started = 1'b1;
                m_t = 0;
                m_err = 1'b0;
                for (int i = 0; i < DIGITS; i++) begin
                    m_code[i] = '0; m_valid[i] = 1'b0;
                end
            end else if (m_started) begin
                pos  = m_t % SCAN_DIV;
                slot = (m_t / SCAN_DIV) % DIGITS;
                e.seg = 7'h7F; e.an = '1;
                if (pos >= BLANK) begin
                    e.an[slot] = 1'b0;
                    e.seg = exp_seg(m_code[slot], m_valid[slot]);
                end
                bad = 1'b0;
                for (int i = 0; i < DIGITS; i++)
                    if (bus.valid_i[i] && $countones(bus.code_i[5*i +: 5]) != 2) bad = 1'b1;
                e.err = m_err;
                if (bus.err_clr_i) e.err = 1'b0;
                if (bus.load_i && bad) e.err = 1'b1;
                exp_q.push_back(e);
                m_err = e.err;
                if (bus.load_i)
                    for (int i = 0; i < DIGITS; i++) begin
                        m_code[i]  = bus.code_i[5*i +: 5];
                        m_valid[i] = bus.valid_i[i];
                    end
                m_t++;
            end
        end
    end

    // Monitor: outputs are stable at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("seg", 32'(bus.seg_o), 32'(e.seg));
                check("an",  32'(bus.an_o),  32'(e.an));
                check("err", 32'(bus.err_o), 32'(e.err));
            end
        end
    end

    task automatic step(input logic r, input logic ld, input logic [5*DIGITS-1:0] c,
                        input logic [DIGITS-1:0] v, input logic clr);
        rst           = r;
        bus.load_i    = ld;
        bus.code_i    = c;
        bus.valid_i   = v;
        bus.err_clr_i = clr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 20'($urandom), 4'($urandom), 1'b0);
    endtask

    task automatic wait_phase(input int phase);
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_t % FRAME == phase) begin
                found = 1'b1;
                break;
            end
            idle(1);
        end
        check("phase_wait", 32'(found), 32'd1);
    endtask

    function automatic logic [4:0] rand_code();
        if ($urandom_range(1) == 0) return codes[$urandom_range(9)];
        return 5'($urandom);
    endfunction

    initial begin
        logic [5*DIGITS-1:0] c;

        // Reset held three cycles while load and err_clr are asserted.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 20'($urandom), 4'($urandom), 1'b1);
        idle(4);

        // Digits 3..0 = 3,2,1,0 across two full frames.
        step(1'b0, 1'b1, {5'b11000, 5'b01001, 5'b10001, 5'b00110}, 4'b1111, 1'b0);
        idle(2 * FRAME);

        // Invalid code on digit 1, then clear.
        step(1'b0, 1'b1, {5'b11000, 5'b01001, 5'b11100, 5'b00110}, 4'b1111, 1'b0);
        idle(FRAME);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        idle(3);

        // Set and clear on the same edge.
        step(1'b0, 1'b1, {5'b11000, 5'b01001, 5'b10001, 5'b00000}, 4'b1111, 1'b1);
        idle(3);
        step(1'b0, 1'b0, '0, '0, 1'b1);

        // Digit 2 disabled with an invalid code: blank slot, no error.
        step(1'b0, 1'b1, {5'b11000, 5'b00000, 5'b10001, 5'b00110}, 4'b1011, 1'b0);
        idle(FRAME + 4);

        // Mid-slot load of digit 0 = 8, then reset in the middle of slot 2.
        wait_phase(4);
        step(1'b0, 1'b1, {5'b11000, 5'b00000, 5'b10001, 5'b10010}, 4'b1011, 1'b0);
        idle(3);
        wait_phase(2 * SCAN_DIV + 4);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        idle(FRAME + 4);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < DIGITS; i++) c[5*i +: 5] = rand_code();
            step($urandom_range(199) == 0, $urandom_range(3) == 0, c,
                 4'($urandom), $urandom_range(15) == 0);
        end
        idle(2);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
